// File: rtl/alu_seq8.sv
// Sequences a shared 4-bit ALU over low/high nibble passes to perform 8-bit
// ADD/SUB/OR/AND/XOR, with an optional carry/borrow fix-up pass on the high nibble.
module alu_seq8 #(
  parameter bit SKIP_FIX = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_code,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       ready,
  output logic       done,
  output logic [7:0] result,
  output logic       flag,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_IDLE = 3'b111;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic       c0_q, c0_d;
  logic       c1_q, c1_d;
  logic [7:0] result_q, result_d;
  logic       flag_q, flag_d;
  logic       is_arith;

  // Only ADD (000) and SUB (001) propagate a carry/borrow between nibbles.
  assign is_arith = (op_q[2:1] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    result_d = result_q;
    flag_d   = flag_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_IDLE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_code;
          state_d = S_LO;
        end
      end
      S_LO: begin
        alu_a   = a_q[3:0];
        alu_b   = b_q[3:0];
        alu_op  = op_q;
        lo_d    = alu_result;
        c0_d    = alu_flag;
        state_d = S_HI;
      end
      S_HI: begin
        alu_a  = a_q[7:4];
        alu_b  = b_q[7:4];
        alu_op = op_q;
        hi_d   = alu_result;
        c1_d   = alu_flag;
        if (is_arith && (!SKIP_FIX || c0_q)) begin
          state_d = S_FIX;
        end else begin
          result_d = {alu_result, lo_q};
          flag_d   = is_arith ? alu_flag : 1'b0;
          state_d  = S_DONE;
        end
      end
      S_FIX: begin
        // Fold the low-nibble carry/borrow into the high nibble; only one of
        // c1 and the fix-pass flag can be set, so OR-ing them is exact.
        alu_a    = hi_q;
        alu_b    = {3'b000, c0_q};
        alu_op   = op_q;
        result_d = {alu_result, lo_q};
        flag_d   = c1_q | alu_flag;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: tb/tb_alu_seq8.sv
// Scoreboard bench for alu_seq8: two instances (SKIP_FIX=1 and SKIP_FIX=0),
// each paired with a behavioural 4-bit ALU, checked by independent monitors.
module tb_alu_seq8;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] OR_ = 3'd2;
  localparam logic [2:0] AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start0;
  logic [2:0] op;
  logic [7:0] a, b;

  logic       ready1, done1, flag1, alu_f1;
  logic [7:0] res1;
  logic [3:0] alu_a1, alu_b1, alu_r1;
  logic [2:0] alu_op1;

  logic       ready0, done0, flag0, alu_f0;
  logic [7:0] res0;
  logic [3:0] alu_a0, alu_b0, alu_r0;
  logic [2:0] alu_op0;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       flag;
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  // Behavioural model of the external 4-bit ALU: {flag, result}.
  function automatic logic [4:0] alu4(input logic [3:0] x, input logic [3:0] y,
                                      input logic [2:0] o);
    case (o)
      3'd0:    return {1'b0, x} + {1'b0, y};
      3'd1:    return {(x < y), 4'(x - y)};
      3'd2:    return {1'b0, x | y};
      3'd3:    return {1'b0, x & y};
      3'd4:    return {1'b0, x ^ y};
      default: return 5'd0;
    endcase
  endfunction

  assign {alu_f1, alu_r1} = alu4(alu_a1, alu_b1, alu_op1);
  assign {alu_f0, alu_r0} = alu4(alu_a0, alu_b0, alu_op0);

  alu_seq8 #(.SKIP_FIX(1'b1)) u_skip (
    .clk(clk), .rst(rst), .start(start1), .op_code(op), .a(a), .b(b),
    .ready(ready1), .done(done1), .result(res1), .flag(flag1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_result(alu_r1), .alu_flag(alu_f1)
  );

  alu_seq8 #(.SKIP_FIX(1'b0)) u_const (
    .clk(clk), .rst(rst), .start(start0), .op_code(op), .a(a), .b(b),
    .ready(ready0), .done(done0), .result(res0), .flag(flag0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
    .alu_result(alu_r0), .alu_flag(alu_f0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin : mon_skip
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done_skip: got result 0x%0h expected no done", res1);
      end else begin
        e = q1.pop_front();
        chk({e.name, "_skip_result"}, res1, e.res);
        chk({e.name, "_skip_flag"}, flag1, e.flag);
        chk({e.name, "_skip_latency"}, cyc - e.start_cyc + 1, e.lat);
        chk({e.name, "_skip_ready_at_done"}, ready1, 0);
      end
    end
  end

  always @(negedge clk) begin : mon_const
    exp_t e;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done_const: got result 0x%0h expected no done", res0);
      end else begin
        e = q0.pop_front();
        chk({e.name, "_const_result"}, res0, e.res);
        chk({e.name, "_const_flag"}, flag0, e.flag);
        chk({e.name, "_const_latency"}, cyc - e.start_cyc + 1, e.lat);
        chk({e.name, "_const_ready_at_done"}, ready0, 0);
      end
    end
  end

  // Issue one request to the selected instance(s); expected response goes to the scoreboard.
  task automatic issue(input bit en1, input bit en0, input bit hold, input bit push,
                       input string nm, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] r, input logic f,
                       input int l1, input int l0);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!((!en1 || ready1) && (!en0 || ready0)) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_ready_timeout: got ready=%0b/%0b expected 1", nm, ready1, ready0);
      return;
    end
    op     = o;
    a      = x;
    b      = y;
    start1 = en1;
    start0 = en0;
    @(posedge clk);
    #1;
    if (!hold) begin
      start1 = 1'b0;
      start0 = 1'b0;
    end
    e.name      = nm;
    e.res       = r;
    e.flag      = f;
    e.start_cyc = cyc;
    if (push && en1) begin
      e.lat = l1;
      q1.push_back(e);
    end
    if (push && en0) begin
      e.lat = l0;
      q0.push_back(e);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((q1.size() != 0 || q0.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q1.size(), q0.size());
      q1.delete();
      q0.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    op     = '0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", ready1, 1);
    chk("reset_done", done1, 0);
    chk("reset_result", res1, 0);
    chk("reset_flag", flag1, 0);
    chk("reset_alu_op", alu_op1, 3'b111);
    chk("reset_alu_ab", {alu_a1, alu_b1}, 0);
    rst = 1'b0;

    //    en1 en0 hold push  name          op    a      b      result flag l1 l0
    issue(1, 1, 0, 1, "add_3c_15",  ADD,  8'h3C, 8'h15, 8'h51, 1'b0, 4, 4);
    issue(1, 1, 0, 1, "add_ff_01",  ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 4, 4);
    issue(1, 1, 0, 1, "add_12_34",  ADD,  8'h12, 8'h34, 8'h46, 1'b0, 3, 4);
    issue(1, 1, 0, 1, "add_80_80",  ADD,  8'h80, 8'h80, 8'h00, 1'b1, 3, 4);
    issue(1, 1, 0, 1, "sub_20_01",  SUB,  8'h20, 8'h01, 8'h1F, 1'b0, 4, 4);
    issue(1, 1, 0, 1, "sub_00_01",  SUB,  8'h00, 8'h01, 8'hFF, 1'b1, 4, 4);
    issue(1, 1, 0, 1, "sub_05_03",  SUB,  8'h05, 8'h03, 8'h02, 1'b0, 3, 4);
    issue(1, 1, 0, 1, "xor_a5_0f",  XOR_, 8'hA5, 8'h0F, 8'hAA, 1'b0, 3, 3);
    issue(1, 1, 0, 1, "or_a0_05",   OR_,  8'hA0, 8'h05, 8'hA5, 1'b0, 3, 3);
    issue(1, 1, 0, 1, "inv_101",    3'd5, 8'hFF, 8'hFF, 8'h00, 1'b0, 3, 3);
    issue(1, 1, 0, 1, "and_f0_3c",  AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 3, 3);
    drain();

    // start with new operands during HI must be ignored
    issue(1, 0, 0, 1, "ign_add",    ADD,  8'h3C, 8'h15, 8'h51, 1'b0, 4, 4);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ign_ready_in_hi", ready1, 0);
    start1 = 1'b1;
    op     = SUB;
    a      = 8'hFF;
    b      = 8'h0F;
    @(negedge clk);
    start1 = 1'b0;
    drain();
    @(negedge clk);
    chk("ign_ready_after_done", ready1, 1);
    repeat (6) @(negedge clk);

    // back-to-back with start held high throughout
    issue(1, 0, 1, 1, "b2b_add",    ADD,  8'h12, 8'h34, 8'h46, 1'b0, 3, 3);
    issue(1, 0, 0, 1, "b2b_sub",    SUB,  8'h05, 8'h03, 8'h02, 1'b0, 3, 3);
    drain();

    // asynchronous reset while both instances sit in FIX
    issue(1, 1, 0, 0, "rst_add",    ADD,  8'h3C, 8'h15, 8'h51, 1'b0, 4, 4);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", {ready1, ready0}, 2'b11);
    chk("async_rst_result", {res1, res0}, 0);
    chk("async_rst_flag", {flag1, flag0}, 0);
    chk("async_rst_done", {done1, done0}, 0);
    chk("async_rst_alu_op", {alu_op1, alu_op0}, 6'b111111);
    #2;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(1, 1, 0, 1, "post_rst",   ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 4, 4);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
